// File: rtl/mdu.sv
// Multiply/divide unit for the E stage: owns HI/LO, runs mult/div with fixed
// latency and exposes start/busy so the hazard logic can stall D-stage MDU ops.
module mdu #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  mduOp,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        req,
    output logic        start,
    output logic        busy,
    output logic [31:0] mduOut
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = ($clog2(MAX_CYCLES + 1) < 4) ? 4 : $clog2(MAX_CYCLES + 1);

    logic [31:0]      hi, lo, hi_tmp, lo_tmp;
    logic [CNT_W-1:0] counter;

    logic        is_arith, is_mul, is_signed_div;
    logic [63:0] product;
    logic [31:0] abs_a, abs_b, div_b, q_mag, r_mag, quot, rem;
    logic [31:0] hi_res, lo_res;

    // Handshake: start pulses for one cycle when an arithmetic op in E is
    // accepted (not flushed, unit idle); busy is high for exactly the
    // following N cycles and HI/LO commit on the edge that drops it.
    assign is_arith = (mduOp >= OP_MULT) && (mduOp <= OP_DIVU);
    assign is_mul   = (mduOp == OP_MULT) || (mduOp == OP_MULTU);
    assign start    = is_arith && !busy && !req;

    // Signed division works on magnitudes so the most-negative / -1 case
    // never depends on overflow behaviour of a signed divide.
    always_comb begin
        is_signed_div = (mduOp == OP_DIV);
        if (mduOp == OP_MULT)
            product = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
        else
            product = {32'd0, srcA} * {32'd0, srcB};
        abs_a = (is_signed_div && srcA[31]) ? (~srcA + 32'd1) : srcA;
        abs_b = (is_signed_div && srcB[31]) ? (~srcB + 32'd1) : srcB;
        div_b = (abs_b == 32'd0) ? 32'd1 : abs_b;
        q_mag = abs_a / div_b;
        r_mag = abs_a % div_b;
        quot  = (is_signed_div && (srcA[31] ^ srcB[31])) ? (~q_mag + 32'd1) : q_mag;
        rem   = (is_signed_div && srcA[31]) ? (~r_mag + 32'd1) : r_mag;
        if (is_mul) begin
            hi_res = product[63:32];
            lo_res = product[31:0];
        end else if (srcB == 32'd0) begin
            // Divide by zero still runs its full latency but commits the old values.
            hi_res = hi;
            lo_res = lo;
        end else begin
            hi_res = rem;
            lo_res = quot;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            hi      <= 32'd0;
            lo      <= 32'd0;
            hi_tmp  <= 32'd0;
            lo_tmp  <= 32'd0;
            counter <= '0;
            busy    <= 1'b0;
        end else if (start) begin
            hi_tmp  <= hi_res;
            lo_tmp  <= lo_res;
            counter <= is_mul ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
            busy    <= 1'b1;
        end else if (busy) begin
            if (counter == CNT_W'(1)) begin
                hi      <= hi_tmp;
                lo      <= lo_tmp;
                busy    <= 1'b0;
                counter <= '0;
            end else begin
                counter <= counter - CNT_W'(1);
            end
        end else if (!req) begin
            if (mduOp == OP_MTHI) hi <= srcA;
            if (mduOp == OP_MTLO) lo <= srcA;
        end
    end

    always_comb begin
        mduOut = 32'd0;
        if (mduOp == OP_MFHI) mduOut = hi;
        else if (mduOp == OP_MFLO) mduOut = lo;
    end

endmodule

// File: tb/tb_mdu.sv
// Directed bench for mdu: read-back expectations go through a scoreboard queue
// that a negedge monitor drains whenever mfhi/mflo is presented.
module tb_mdu;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    localparam logic [3:0] NONE  = 4'd0;
    localparam logic [3:0] MULT  = 4'd1;
    localparam logic [3:0] MULTU = 4'd2;
    localparam logic [3:0] DIV   = 4'd3;
    localparam logic [3:0] DIVU  = 4'd4;
    localparam logic [3:0] MFHI  = 4'd5;
    localparam logic [3:0] MFLO  = 4'd6;
    localparam logic [3:0] MTHI  = 4'd7;
    localparam logic [3:0] MTLO  = 4'd8;

    logic        clk;
    logic        reset;
    logic [3:0]  mduOp;
    logic [31:0] srcA, srcB;
    logic        req;
    logic        start, busy;
    logic [31:0] mduOut;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] exp_q[$];
    string       name_q[$];

    mdu #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk    (clk),
        .reset  (reset),
        .mduOp  (mduOp),
        .srcA   (srcA),
        .srcB   (srcB),
        .req    (req),
        .start  (start),
        .busy   (busy),
        .mduOut (mduOut)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    // scoreboard monitor
    always @(negedge clk) begin
        if (!reset && (mduOp == MFHI || mduOp == MFLO)) begin
            vectors++;
            if (exp_q.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_read: got %h, required no read", mduOut);
            end else begin
                logic [31:0] e;
                string       n;
                e = exp_q.pop_front();
                n = name_q.pop_front();
                if (mduOut !== e) begin
                    miscompares++;
                    $display("FAIL %s: got %h, required %h", n, mduOut, e);
                end
            end
        end
        if (start === 1'b1 && busy === 1'b1) begin
            miscompares++;
            $display("FAIL start_busy_overlap: got start=1 busy=1, required not both");
        end
    end

    // driver tasks: each starts at posedge+1 of its cycle and returns at the next one
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
        mduOp = NONE;
        req   = 1'b0;
    endtask

    task automatic issue(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic rq, input logic exp_start);
        mduOp = op;
        srcA  = a;
        srcB  = b;
        req   = rq;
        @(negedge clk);
        check({name, "_start"}, {31'd0, start}, {31'd0, exp_start});
        advance();
    endtask

    task automatic wait_done(input string name, input int exp_n, input logic hold_req);
        int cnt;
        cnt = 0;
        for (int i = 0; i < 200; i++) begin
            if (!busy) break;
            cnt++;
            req = hold_req;
            @(posedge clk);
            #1;
        end
        req = 1'b0;
        check({name, "_busy_cycles"}, 32'(cnt), 32'(exp_n));
    endtask

    task automatic read(input string name, input logic [3:0] op, input logic [31:0] exp);
        exp_q.push_back(exp);
        name_q.push_back(name);
        mduOp = op;
        @(negedge clk);
        advance();
    endtask

    task automatic move_to(input logic [3:0] op, input logic [31:0] a, input logic rq);
        mduOp = op;
        srcA  = a;
        req   = rq;
        advance();
    endtask

    task automatic arith(input string name, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
        issue(name, op, a, b, 1'b0, 1'b1);
        wait_done(name, (op == MULT || op == MULTU) ? MULT_N : DIV_N, 1'b0);
        read({name, "_hi"}, MFHI, exp_hi);
        read({name, "_lo"}, MFLO, exp_lo);
    endtask

    initial begin
        reset = 1'b1;
        mduOp = NONE;
        srcA  = 32'd0;
        srcB  = 32'd0;
        req   = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;

        check("reset_busy", {31'd0, busy}, 32'd0);
        read("reset_hi", MFHI, 32'h0);
        read("reset_lo", MFLO, 32'h0);

        arith("mult_neg2x3", MULT,  32'hFFFF_FFFE, 32'd3,        32'hFFFF_FFFF, 32'hFFFF_FFFA);
        arith("multu_max",   MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001);
        arith("div_m7_2",    DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD);
        arith("div_7_m2",    DIV,   32'd7,        32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD);
        arith("divu_7_2",    DIVU,  32'd7,        32'd2,        32'h0000_0001, 32'h0000_0003);
        arith("divu_max_16", DIVU,  32'hFFFF_FFFF, 32'd16,       32'h0000_000F, 32'h0FFF_FFFF);
        arith("div_ovf",     DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000);

        move_to(MTHI, 32'h1234, 1'b0);
        move_to(MTLO, 32'h5678, 1'b0);
        read("mthi_hi", MFHI, 32'h1234);
        read("mtlo_lo", MFLO, 32'h5678);

        issue("mult_flushed", MULT, 32'd3, 32'd4, 1'b1, 1'b0);
        check("mult_flushed_busy", {31'd0, busy}, 32'd0);
        move_to(MTLO, 32'hAAAA, 1'b1);
        read("flushed_hi", MFHI, 32'h1234);
        read("flushed_lo", MFLO, 32'h5678);

        arith("div_by_zero",  DIV,  32'd5, 32'd0, 32'h1234, 32'h5678);
        arith("divu_by_zero", DIVU, 32'd9, 32'd0, 32'h1234, 32'h5678);

        // flush while a mult is in flight, then accept in the first idle cycle
        issue("mult_req_inflight", MULT, 32'd6, 32'd7, 1'b0, 1'b1);
        wait_done("mult_req_inflight", MULT_N, 1'b1);
        issue("multu_b2b", MULTU, 32'd2, 32'd3, 1'b0, 1'b1);
        wait_done("multu_b2b", MULT_N, 1'b0);
        read("multu_b2b_hi", MFHI, 32'h0);
        read("multu_b2b_lo", MFLO, 32'h6);

        move_to(MTHI, 32'hDEAD, 1'b0);
        move_to(MTLO, 32'hBEEF, 1'b0);
        issue("div_reset", DIV, 32'd100, 32'd7, 1'b0, 1'b1);
        advance();
        advance();
        reset = 1'b1;
        advance();
        reset = 1'b0;
        check("reset_mid_busy", {31'd0, busy}, 32'd0);
        read("reset_mid_hi", MFHI, 32'h0);
        read("reset_mid_lo", MFLO, 32'h0);
        arith("mult_after_reset", MULT, 32'd5, 32'hFFFF_FFFB, 32'hFFFF_FFFF, 32'hFFFF_FFE7);

        repeat (3) advance();
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
